seg_execute_mem_latch: RTL

EX/MEM pipeline register, directly downstream of the execute stage's seg_execute_alu and seg_execute_alu_control pair.
- Captures ALU result, zero flag, store data, destination register and MEM/WB control each cycle.
- Supports stall (hold), flush (bubble injection) and a valid bit.
- Resolves BEQ-style branches from the registered zero flag for the fetch stage and the forwarding unit.

---
 rtl/seg_execute_mem_latch_if.sv | 59 +++++
 rtl/seg_execute_mem_latch.sv | 91 +++++++++
 2 files changed

// File: rtl/seg_execute_mem_latch_if.sv
// EX/MEM latch bus: execute-stage inputs (i_*) and registered EX/MEM outputs (o_*).
// EX_MEM_STATS_EN adds the bubble/stall counter outputs.
interface seg_execute_mem_latch_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_PC   = 32
);
    logic               i_stall;
    logic               i_flush;
    logic               i_valid;
    logic [NB_DATA-1:0] i_ALUOut;
    logic               i_zero;
    logic [NB_DATA-1:0] i_store_data;
    logic [NB_REG-1:0]  i_write_reg;
    logic [NB_PC-1:0]   i_branch_target;
    logic               i_RegWrite;
    logic               i_MemtoReg;
    logic               i_MemRead;
    logic               i_MemWrite;
    logic               i_Branch;

    logic               o_valid;
    logic [NB_DATA-1:0] o_ALUOut;
    logic               o_zero;
    logic [NB_DATA-1:0] o_store_data;
    logic [NB_REG-1:0]  o_write_reg;
    logic               o_RegWrite;
    logic               o_MemtoReg;
    logic               o_MemRead;
    logic               o_MemWrite;
    logic               o_Branch;
    logic [NB_PC-1:0]   o_branch_target;
    logic               o_PCSrc;
    logic               o_fwd_RegWrite;
`ifdef EX_MEM_STATS_EN
    logic [15:0]        o_bubble_count;
    logic [15:0]        o_stall_count;
`endif

    modport master (
`ifdef EX_MEM_STATS_EN
        input  o_bubble_count, o_stall_count,
`endif
        output i_stall, i_flush, i_valid, i_ALUOut, i_zero, i_store_data, i_write_reg,
               i_branch_target, i_RegWrite, i_MemtoReg, i_MemRead, i_MemWrite, i_Branch,
        input  o_valid, o_ALUOut, o_zero, o_store_data, o_write_reg, o_RegWrite, o_MemtoReg,
               o_MemRead, o_MemWrite, o_Branch, o_branch_target, o_PCSrc, o_fwd_RegWrite
    );

    modport slave (
`ifdef EX_MEM_STATS_EN
        output o_bubble_count, o_stall_count,
`endif
        input  i_stall, i_flush, i_valid, i_ALUOut, i_zero, i_store_data, i_write_reg,
               i_branch_target, i_RegWrite, i_MemtoReg, i_MemRead, i_MemWrite, i_Branch,
        output o_valid, o_ALUOut, o_zero, o_store_data, o_write_reg, o_RegWrite, o_MemtoReg,
               o_MemRead, o_MemWrite, o_Branch, o_branch_target, o_PCSrc, o_fwd_RegWrite
    );
endinterface

// File: rtl/seg_execute_mem_latch.sv
// EX/MEM pipeline register with stall/flush/valid and registered-zero branch resolution.
// Optional EX_MEM_STATS_EN adds saturating bubble and stall counters.
module seg_execute_mem_latch #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_PC   = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    seg_execute_mem_latch_if.slave  bus
);
    logic               r_valid;
    logic [NB_DATA-1:0] r_ALUOut;
    logic               r_zero;
    logic [NB_DATA-1:0] r_store_data;
    logic [NB_REG-1:0]  r_write_reg;
    logic [NB_PC-1:0]   r_branch_target;
    logic               r_RegWrite;
    logic               r_MemtoReg;
    logic               r_MemRead;
    logic               r_MemWrite;
    logic               r_Branch;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset || (!i_reset && bus.i_flush)) begin
            r_valid         <= 1'b0;
            r_ALUOut        <= '0;
            r_zero          <= 1'b0;
            r_store_data    <= '0;
            r_write_reg     <= '0;
            r_branch_target <= '0;
            r_RegWrite      <= 1'b0;
            r_MemtoReg      <= 1'b0;
            r_MemRead       <= 1'b0;
            r_MemWrite      <= 1'b0;
            r_Branch        <= 1'b0;
        end else if (!bus.i_stall) begin
            r_valid         <= bus.i_valid;
            r_ALUOut        <= bus.i_ALUOut;
            r_zero          <= bus.i_zero;
            r_store_data    <= bus.i_store_data;
            r_write_reg     <= bus.i_write_reg;
            r_branch_target <= bus.i_branch_target;
            r_RegWrite      <= bus.i_valid & bus.i_RegWrite;
            r_MemtoReg      <= bus.i_valid & bus.i_MemtoReg;
            // A store wins over a load so the memory stage never sees both strobes.
            r_MemRead       <= bus.i_valid & bus.i_MemRead & ~bus.i_MemWrite;
            r_MemWrite      <= bus.i_valid & bus.i_MemWrite;
            r_Branch        <= bus.i_valid & bus.i_Branch;
        end
    end

    assign bus.o_valid         = r_valid;
    assign bus.o_ALUOut        = r_ALUOut;
    assign bus.o_zero          = r_zero;
    assign bus.o_store_data    = r_store_data;
    assign bus.o_write_reg     = r_write_reg;
    assign bus.o_branch_target = r_branch_target;
    assign bus.o_RegWrite      = r_RegWrite;
    assign bus.o_MemtoReg      = r_MemtoReg;
    assign bus.o_MemRead       = r_MemRead;
    assign bus.o_MemWrite      = r_MemWrite;
    assign bus.o_Branch        = r_Branch;
    assign bus.o_PCSrc         = r_valid & r_Branch & r_zero;
    assign bus.o_fwd_RegWrite  = r_valid & r_RegWrite & (r_write_reg != '0);

`ifdef EX_MEM_STATS_EN
    logic        w_bubble_load;
    logic        w_stall_hold;
    logic [15:0] r_bubble_count;
    logic [15:0] r_stall_count;

    assign w_bubble_load = bus.i_flush | (~bus.i_stall & ~bus.i_valid);
    assign w_stall_hold  = bus.i_stall & ~bus.i_flush;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bubble_count <= '0;
            r_stall_count  <= '0;
        end else begin
            if (w_bubble_load && (r_bubble_count != 16'hFFFF))
                r_bubble_count <= r_bubble_count + 16'd1;
            if (w_stall_hold && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign bus.o_bubble_count = r_bubble_count;
    assign bus.o_stall_count  = r_stall_count;
`endif
endmodule
